uart_alu_iface: RTL and testbench

// - Sequencer between the UART receiver and the ALU, and between the ALU and the UART transmitter.
// - Collects three received bytes in order: operand A, operand B, opcode. Drives the ALU, captures the result and hands one byte to TX.
// - Sits inside top_level: the rx done/data outputs feed this block; this block feeds tx start/data and watches tx done.

---
 rtl/uart_alu_iface_pkg.sv | 26 ++
 rtl/uart_alu_iface_op_valid_check.sv | 32 +++
 rtl/uart_alu_iface.sv | 122 ++++++++++++
 tb/tb_uart_alu_iface.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_iface_pkg.sv
// Shared definitions for the UART/ALU sequencer and the ALU: widths,
// opcode encodings and the sequencer state encoding.
package uart_alu_iface_pkg;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

endpackage

// File: rtl/uart_alu_iface_op_valid_check.sv
// Combinational opcode whitelist: a received byte is a legal opcode only
// when its upper bits are zero and its low bits name a supported operation.
module uart_alu_iface_op_valid_check
  import uart_alu_iface_pkg::*;
#(
  parameter int NB_DATA = uart_alu_iface_pkg::NB_DATA,
  parameter int NB_OP   = uart_alu_iface_pkg::NB_OP
) (
  input  logic [NB_DATA-1:0] i_byte,
  output logic               o_valid
);

  logic [NB_OP-1:0] low_bits;
  logic             upper_zero;
  logic             known_op;

  assign low_bits   = i_byte[NB_OP-1:0];
  assign upper_zero = (i_byte[NB_DATA-1:NB_OP] == '0);

  // Match the low bits against the supported opcode set
  always_comb begin
    known_op = 1'b0;
    case (low_bits)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRL, OP_SRA: known_op = 1'b1;
      default:                        known_op = 1'b0;
    endcase
  end

  assign o_valid = upper_zero & known_op;

endmodule

// File: rtl/uart_alu_iface.sv
// Sequencer between UART RX, the ALU and UART TX. Collects operand A,
// operand B and an opcode byte, lets the ALU settle for one cycle, captures
// the result and requests a single-byte transmission, then waits for TX.
module uart_alu_iface
  import uart_alu_iface_pkg::*;
#(
  parameter int NB_DATA = uart_alu_iface_pkg::NB_DATA,
  parameter int NB_OP   = uart_alu_iface_pkg::NB_OP
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_op_err
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               op_err_q, op_err_d;
  logic               op_valid;

  uart_alu_iface_op_valid_check #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_op_valid_check (
    .i_byte  (i_rx_data),
    .o_valid (op_valid)
  );

  // State and datapath registers; reset clears everything immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_WAIT_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      op_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
      op_err_q  <= op_err_d;
    end
  end

  // Next-state and register-load decisions; rx bytes outside the three
  // collection states and tx_done outside WAIT_TX fall through unused
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    op_err_d  = 1'b0;
    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          b_d     = i_rx_data;
          state_d = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          if (op_valid) begin
            op_d    = i_rx_data[NB_OP-1:0];
            state_d = ST_EXEC;
          end else begin
            // Rejected opcode keeps the previous op and restarts collection
            op_err_d = 1'b1;
            state_d  = ST_WAIT_A;
          end
        end
      end
      ST_EXEC: begin
        // ALU inputs have been stable for a full cycle; take its result
        tx_data_d = i_alu_result;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_d = ST_WAIT_A;
        end
      end
      default: begin
        state_d = ST_WAIT_A;
      end
    endcase
  end

  // Output decode: the TX request is a Moore pulse for the single SEND cycle
  always_comb begin
    o_tx_start = (state_q == ST_SEND);
    o_alu_a    = a_q;
    o_alu_b    = b_q;
    o_alu_op   = op_q;
    o_tx_data  = tx_data_q;
    o_op_err   = op_err_q;
  end

endmodule

// File: tb/tb_uart_alu_iface.sv
// Directed bench for uart_alu_iface with a behavioural ALU and a TX model
// that answers each start request with tx_done 160 cycles later.
module tb_uart_alu_iface;
  import uart_alu_iface_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       op_err;

  int n_cmp = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  bit tx_busy = 0;

  uart_alu_iface dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_result),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_op_err     (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: shifts move A by B positions
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_SRL:  alu_result = alu_a >> alu_b;
      OP_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b);
      default: alu_result = 8'h00;
    endcase
  end

  always @(negedge clk) begin
    if (op_err === 1'b1) err_cnt++;
  end

  // TX model: count starts, check data hold, answer with tx_done
  initial begin
    logic [7:0] cap;
    bit         stable;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        start_cnt++;
        tx_busy = 1;
        cap     = tx_data;
        stable  = 1;
        repeat (159) begin
          @(negedge clk);
          if (tx_data !== cap) stable = 0;
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        tx_busy = 0;
        n_cmp++;
        if (!stable) begin
          n_fail++;
          $display("FAIL tx_data_hold: data changed while waiting for TX, captured %h now %h", cap, tx_data);
        end
      end
    end
  end

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  // Sends the opcode byte and samples start/err/data on the following cycles
  task automatic op_and_sample(input logic [7:0] op, output logic s0, output logic s1,
                               output logic s2, output logic e0, output logic e1,
                               output logic [7:0] d);
    rx_pulse(op);
    s0 = tx_start;
    e0 = op_err;
    @(posedge clk);
    #1;
    s1 = tx_start;
    e1 = op_err;
    d  = tx_data;
    @(posedge clk);
    #1;
    s2 = tx_start;
  endtask

  task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         output logic s0, output logic s1, output logic s2,
                         output logic e0, output logic e1, output logic [7:0] d);
    rx_pulse(a);
    rx_pulse(b);
    op_and_sample(op, s0, s1, s2, e0, e1, d);
  endtask

  task automatic wait_tx_idle(output bit timed_out);
    for (int i = 0; i < 400 && tx_busy; i++) @(posedge clk);
    timed_out = tx_busy;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, op_err} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: a=%h b=%h op=%h tx=%h start=%b err=%b, required all zero",
               alu_a, alu_b, alu_op, tx_data, tx_start, op_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    logic s0, s1, s2, e0, e1;
    logic [7:0] d;
    bit to;
    int sc, ec;
    sc = start_cnt;
    ec = err_cnt;
    run_seq(8'h03, 8'h0C, 8'h20, s0, s1, s2, e0, e1, d);
    n_cmp++;
    if ({s0, s1, s2} !== 3'b010) begin
      n_fail++;
      $display("FAIL add_start_timing: start samples %b%b%b, required 010", s0, s1, s2);
    end
    n_cmp++;
    if (d !== 8'h0F) begin n_fail++; $display("FAIL add_data: got %h, required 0f", d); end
    wait_tx_idle(to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL add_tx_timeout: tx never completed"); end
    n_cmp++;
    if (start_cnt - sc !== 1 || err_cnt !== ec) begin
      n_fail++;
      $display("FAIL add_pulse_counts: starts=%0d errs=%0d, required 1 and 0", start_cnt - sc, err_cnt - ec);
    end
  endtask

  task automatic test_sub_sra;
    logic s0, s1, s2, e0, e1;
    logic [7:0] d;
    bit to;
    run_seq(8'h03, 8'h0C, 8'h22, s0, s1, s2, e0, e1, d);
    n_cmp++;
    if (d !== 8'hF7 || s1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_wrap: data %h start %b, required f7 and 1", d, s1);
    end
    wait_tx_idle(to);
    run_seq(8'h80, 8'h01, 8'h03, s0, s1, s2, e0, e1, d);
    n_cmp++;
    if (d !== 8'hC0 || s1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sra: data %h start %b, required c0 and 1", d, s1);
    end
    wait_tx_idle(to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL sra_tx_timeout: tx never completed"); end
  endtask

  task automatic test_bad_op;
    logic s0, s1, s2, e0, e1;
    logic [7:0] d;
    bit to;
    int sc;
    sc = start_cnt;
    run_seq(8'h05, 8'h06, 8'h3F, s0, s1, s2, e0, e1, d);
    n_cmp++;
    if ({e0, e1} !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_op_err_pulse: err samples %b%b, required 10", e0, e1);
    end
    repeat (5) @(posedge clk);
    n_cmp++;
    if (start_cnt !== sc || alu_op !== 6'h03) begin
      n_fail++;
      $display("FAIL bad_op_no_start: starts=%0d op=%h, required 0 and 03", start_cnt - sc, alu_op);
    end
    run_seq(8'h01, 8'h02, 8'h20, s0, s1, s2, e0, e1, d);
    n_cmp++;
    if (d !== 8'h03 || s1 !== 1'b1) begin
      n_fail++;
      $display("FAIL after_bad_add: data %h start %b, required 03 and 1", d, s1);
    end
    wait_tx_idle(to);
    sc = start_cnt;
    run_seq(8'h05, 8'h06, 8'hE0, s0, s1, s2, e0, e1, d);
    repeat (3) @(posedge clk);
    n_cmp++;
    if ({e0, e1} !== 2'b10 || start_cnt !== sc || alu_op !== 6'h20) begin
      n_fail++;
      $display("FAIL upper_bits_op: err %b%b starts=%0d op=%h, required 10, 0, 20",
               e0, e1, start_cnt - sc, alu_op);
    end
  endtask

  task automatic test_drop_in_tx;
    logic s0, s1, s2, e0, e1;
    logic [7:0] d;
    bit to;
    run_seq(8'h04, 8'h05, 8'h20, s0, s1, s2, e0, e1, d);
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    n_cmp++;
    if (alu_a !== 8'h04 || alu_b !== 8'h05) begin
      n_fail++;
      $display("FAIL drop_in_tx_regs: a=%h b=%h, required 04 05", alu_a, alu_b);
    end
    wait_tx_idle(to);
    run_seq(8'h01, 8'h01, 8'h20, s0, s1, s2, e0, e1, d);
    n_cmp++;
    if (d !== 8'h02 || s1 !== 1'b1) begin
      n_fail++;
      $display("FAIL after_drop: data %h start %b, required 02 and 1", d, s1);
    end
    wait_tx_idle(to);
  endtask

  task automatic test_reset_mid;
    logic s0, s1, s2, e0, e1;
    logic [7:0] d;
    bit to;
    int sc;
    rx_pulse(8'h07);
    rx_pulse(8'h09);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, op_err} !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: a=%h b=%h op=%h tx=%h start=%b err=%b, required all zero",
               alu_a, alu_b, alu_op, tx_data, tx_start, op_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sc = start_cnt;
    rx_pulse(8'h20);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (alu_a !== 8'h20 || start_cnt !== sc) begin
      n_fail++;
      $display("FAIL post_reset_as_a: a=%h starts=%0d, required 20 and 0", alu_a, start_cnt - sc);
    end
    rx_pulse(8'h05);
    op_and_sample(8'h20, s0, s1, s2, e0, e1, d);
    n_cmp++;
    if (d !== 8'h25 || {s0, s1, s2} !== 3'b010) begin
      n_fail++;
      $display("FAIL post_reset_seq: data %h starts %b%b%b, required 25 and 010", d, s0, s1, s2);
    end
    wait_tx_idle(to);
  endtask

  task automatic test_back_to_back;
    logic s0, s1, s2, e0, e1;
    logic [7:0] d;
    bit to;
    int sc;
    sc = start_cnt;
    run_seq(8'h10, 8'h20, 8'h20, s0, s1, s2, e0, e1, d);
    n_cmp++;
    if (d !== 8'h30) begin n_fail++; $display("FAIL b2b_add: got %h, required 30", d); end
    wait_tx_idle(to);
    run_seq(8'hF0, 8'h3C, 8'h24, s0, s1, s2, e0, e1, d);
    n_cmp++;
    if (d !== 8'h30) begin n_fail++; $display("FAIL b2b_and: got %h, required 30", d); end
    wait_tx_idle(to);
    run_seq(8'h0F, 8'hF0, 8'h27, s0, s1, s2, e0, e1, d);
    n_cmp++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL b2b_nor: got %h, required 00", d); end
    wait_tx_idle(to);
    n_cmp++;
    if (start_cnt - sc !== 3 || to) begin
      n_fail++;
      $display("FAIL b2b_count: starts=%0d timeout=%b, required 3 and 0", start_cnt - sc, to);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sra();
    test_bad_op();
    test_drop_in_tx();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
